mayo_keygen_axil_slave: RTL and testbench
=========================================

Name: mayo_keygen_axil_slave

Overview:
AXI4-Lite responder (slave) register block for the MAYO keygen IP; terminates the S00_AXI port driven by the PS or the VIP master.
- Decodes word-aligned accesses into a CTRL/STATUS/config register file.
- Issues a one-cycle start pulse to the keygen core and captures its busy/done status.
- Independent write and read channel FSMs; at most one outstanding transaction per direction.

Parameters:
ADDR_W, 6, AXI address width; only bits [ADDR_W-1:2] are decoded.
DATA_W, 32, AXI data width; fixed at 32 (elaboration error otherwise).
NUM_CFG, 4, number of RW config registers following CTRL/STATUS.

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  OKAY=00, SLVERR=10
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  ADDR_W  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid/s_axi_rready  out/in  1  R handshake
core_start_o  out  1  one-cycle start pulse
core_busy_i  in  1  keygen running
core_done_i  in  1  one-cycle completion pulse
cfg_o  out  NUM_CFG*32  config registers, flattened, reg0 in LSBs

Behaviour:
- One clock ACLK. ARESETN is asynchronous, active-low. Reset values: all readies, bvalid, rvalid, core_start_o = 0; bresp, rresp, rdata, cfg_o = 0; done_sticky = 0; both FSMs idle.
- Address map (word index = addr[ADDR_W-1:2]):
  - 0 CTRL: bit0 START (write-1 issues pulse; reads 0); bits[31:1] RW scratch.
  - 1 STATUS RO: bit0 = core_busy_i; bit1 = done_sticky; write-1-to-clear on bit1 only; other bits read 0.
  - 2..NUM_CFG+1: CFG RW.
  - Any higher index: SLVERR, no state change, rdata=0.
- Write FSM states:
  - W_IDLE: awready=wready=1. AW only -> W_HAVE_A. W only -> W_HAVE_D. Both same cycle -> commit, go to W_RESP.
  - W_HAVE_A: wready=1, awready=0. On W -> commit, W_RESP.
  - W_HAVE_D: awready=1, wready=0. On AW -> commit, W_RESP.
  - W_RESP: bvalid=1, bresp held until bready; then W_IDLE. No readies asserted, so backpressure is unbounded.
- Commit: byte lane i is updated only when wstrb[i]=1. bvalid rises the cycle after the commit cycle.
- START: if wstrb[0]=1 and wdata[0]=1 on CTRL, core_start_o=1 for exactly the cycle after commit. It is pulsed even when core_busy_i=1; the core ignores it.
- Read FSM: R_IDLE with arready=1. On AR handshake, latch rdata/rresp and go to R_RESP. R_RESP holds rvalid=1 with stable data until rready, then R_IDLE. Read latency: rvalid one cycle after AR handshake.
- Read data is sampled at the AR handshake cycle. A write committing in the same cycle is not visible; the old value is returned.
- done_sticky:
  - Set on core_done_i.
  - Cleared by a W1C commit.
  - Simultaneous set and clear -> set wins.
- Unaligned addr[1:0] is ignored (word access).
- Reset mid-transaction aborts all state; the master must reissue the transaction.

Optional Feature:
MAYO_AXIL_IRQ_EN
- Defined:
  - Adds output irq_o (1 bit, reset 0) = done_sticky & CTRL[1].
  - CTRL[1] becomes the IRQ enable.
  - irq_o is registered and deasserts the cycle after W1C clears done_sticky.
- Undefined: no irq_o port; CTRL[1] is plain scratch.

Decomposition:
- Package mayo_axil_pkg:
  - resp constants RESP_OKAY / RESP_SLVERR;
  - register index localparams REG_CTRL=0, REG_STATUS=1, REG_CFG0=2;
  - typedef enum for write FSM states;
  - typedef enum for read FSM states.
- One natural sub-module: mayo_axil_strb_merge (combinational byte-enable merge of old word, wdata and wstrb), reused by every RW register.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00/0x08/0x0C/0x10, then read back -> CTRL reads 0x0 (START self-clears); 0x08=0x2, 0x0C=0x3, 0x10=0x4; all OKAY.
- Write 0xAABBCCDD to 0x08 with wstrb=0b0101 over prior 0x11223344 -> read 0x11BB33DD.
- Present W three cycles before AW to 0x0C, with bready low for 5 cycles -> single commit, bvalid held stable, bresp=OKAY.
- Write 0x1 to CTRL -> core_start_o high exactly one cycle, the cycle after commit.
  - Then pulse core_done_i -> STATUS reads 0x2 (busy=0).
  - Write 0x2 to STATUS -> STATUS reads 0x0.
- Write/read address 0x3C with NUM_CFG=4 -> bresp=SLVERR and rresp=SLVERR with rdata=0; all registers unchanged.
- Assert ARESETN low while in W_RESP -> bvalid=0 immediately (asynchronous reset); after release all registers read 0.

Source files
------------

// File: rtl/mayo_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mayo_axil_pkg
//  Brief    : Shared constants and FSM state types for the MAYO keygen
//             AXI4-Lite register block.
//  Revision : 1.0 - initial release
// ============================================================================
package mayo_axil_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register word indices
  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_CFG0   = 2;

  // Write channel FSM
  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  // Read channel FSM
  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/mayo_axil_strb_merge.sv
`default_nettype none
// ============================================================================
//  Module   : mayo_axil_strb_merge
//  Brief    : Byte-enable merge of an existing 32-bit register word with new
//             write data; lane i takes wr_data only when wr_strb[i] is set.
//  Revision : 1.0 - initial release
// ============================================================================
module mayo_axil_strb_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [31:0] merged
);

  genvar g_i;
  generate
    for (g_i = 0; g_i < 4; g_i++) begin : g_lane
      assign merged[g_i*8 +: 8] = wr_strb[g_i] ? wr_data[g_i*8 +: 8] : old_word[g_i*8 +: 8];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mayo_keygen_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module   : mayo_keygen_axil_slave
//  Brief    : AXI4-Lite responder for the MAYO keygen IP. CTRL / STATUS /
//             NUM_CFG config registers, start pulse and done capture.
//             Optional macro MAYO_AXIL_IRQ_EN adds irq_o with CTRL[1] as
//             the interrupt enable.
//  Revision : 1.0 - initial release
// ============================================================================
module mayo_keygen_axil_slave
  import mayo_axil_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int NUM_CFG = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  core_start_o,
  input  logic                  core_busy_i,
  input  logic                  core_done_i,
`ifdef MAYO_AXIL_IRQ_EN
  output logic                  irq_o,
`endif
  output logic [NUM_CFG*32-1:0] cfg_o
);

  localparam int IDX_W   = ADDR_W - 2;
  localparam int REG_END = REG_CFG0 + NUM_CFG;

  generate
    if (DATA_W != 32) begin : g_data_w_check
      $error("mayo_keygen_axil_slave: DATA_W must be 32");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wr_state_t        r_wr_state;
  wr_state_t        w_wr_state_nxt;
  logic             r_awready;
  logic             r_wready;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic [IDX_W-1:0] r_aw_idx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_commit;
  logic             w_awready_nxt;
  logic             w_wready_nxt;
  logic             w_bvalid_nxt;
  logic [IDX_W-1:0] w_cm_idx;
  logic [31:0]      w_cm_word;
  logic [31:0]      w_cm_data;
  logic [3:0]       w_cm_strb;
  logic             w_cm_valid;

  assign w_aw_hs = s_axi_awvalid & r_awready;
  assign w_w_hs  = s_axi_wvalid & r_wready;

  // Commit operands come from the latched half of the transaction when one
  // channel arrived early, otherwise straight from the bus.
  assign w_cm_idx   = (r_wr_state == W_HAVE_A) ? r_aw_idx : s_axi_awaddr[ADDR_W-1:2];
  assign w_cm_data  = (r_wr_state == W_HAVE_D) ? r_wdata  : s_axi_wdata;
  assign w_cm_strb  = (r_wr_state == W_HAVE_D) ? r_wstrb  : s_axi_wstrb;
  assign w_cm_word  = 32'(w_cm_idx);
  assign w_cm_valid = (w_cm_word < REG_END);

  // Write FSM next state; readies/bvalid are registered copies of the next state
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_commit       = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wr_state_nxt = W_RESP;
          w_commit       = 1'b1;
        end else if (w_aw_hs) begin
          w_wr_state_nxt = W_HAVE_A;
        end else if (w_w_hs) begin
          w_wr_state_nxt = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_w_hs) begin
          w_wr_state_nxt = W_RESP;
          w_commit       = 1'b1;
        end
      end
      W_HAVE_D: begin
        if (w_aw_hs) begin
          w_wr_state_nxt = W_RESP;
          w_commit       = 1'b1;
        end
      end
      W_RESP: begin
        if (r_bvalid && s_axi_bready) begin
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
    w_awready_nxt = (w_wr_state_nxt == W_IDLE) || (w_wr_state_nxt == W_HAVE_D);
    w_wready_nxt  = (w_wr_state_nxt == W_IDLE) || (w_wr_state_nxt == W_HAVE_A);
    w_bvalid_nxt  = (w_wr_state_nxt == W_RESP);
  end

  // Write FSM state, handshake outputs, early-channel capture and response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_awready  <= w_awready_nxt;
      r_wready   <= w_wready_nxt;
      r_bvalid   <= w_bvalid_nxt;
      if (w_aw_hs) r_aw_idx <= s_axi_awaddr[ADDR_W-1:2];
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
      end
      if (w_commit) r_bresp <= w_cm_valid ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:1] r_ctrl;
  logic [31:0] r_cfg [NUM_CFG];
  logic        r_done_sticky;
  logic        r_core_start;
  logic [31:0] w_ctrl_merged;
  logic [31:0] w_cfg_merged [NUM_CFG];
  logic        w_done_clr;

  mayo_axil_strb_merge u_ctrl_merge (
    .old_word (
      {r_ctrl, 1'b0}),
    .wr_data  (w_cm_data),
    .wr_strb  (w_cm_strb),
    .merged   (w_ctrl_merged)
  );

  genvar g_k;
  generate
    for (g_k = 0; g_k < NUM_CFG; g_k++) begin : g_cfg
      mayo_axil_strb_merge u_cfg_merge (
        .old_word (r_cfg[g_k]),
        .wr_data  (w_cm_data),
        .wr_strb  (w_cm_strb),
        .merged   (w_cfg_merged[g_k])
      );
      assign cfg_o[g_k*32 +: 32] = r_cfg[g_k];
    end
  endgenerate

  // CTRL scratch, CFG registers and the START pulse, all updated on commit
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_ctrl       <= '0;
      r_core_start <= 1'b0;
      for (int k = 0; k < NUM_CFG; k++) r_cfg[k] <= '0;
    end else begin
      r_core_start <= w_commit && (w_cm_word == REG_CTRL) && w_cm_strb[0] && w_cm_data[0];
      if (w_commit && (w_cm_word == REG_CTRL)) r_ctrl <= w_ctrl_merged[31:1];
      for (int k = 0; k < NUM_CFG; k++) begin
        if (w_commit && (w_cm_word == REG_CFG0 + k)) r_cfg[k] <= w_cfg_merged[k];
      end
    end
  end

  // STATUS bit1 lives in byte lane 0, so the clear needs that lane enabled
  assign w_done_clr = w_commit && (w_cm_word == REG_STATUS) && w_cm_strb[0] && w_cm_data[1];

  // Done capture: a new completion beats a simultaneous clear
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_done_sticky <= 1'b0;
    end else if (core_done_i) begin
      r_done_sticky <= 1'b1;
    end else if (w_done_clr) begin
      r_done_sticky <= 1'b0;
    end
  end

  assign core_start_o = r_core_start;

`ifdef MAYO_AXIL_IRQ_EN
  logic r_irq;

  // Interrupt follows the registered sticky flag gated by CTRL[1]
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_done_sticky & r_ctrl[1];
    end
  end

  assign irq_o = r_irq;
`endif

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_t   r_rd_state;
  rd_state_t   w_rd_state_nxt;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs;
  logic [31:0] w_rd_word;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;

  assign w_ar_hs   = s_axi_arvalid & r_arready;
  assign w_rd_word = 32'(s_axi_araddr[ADDR_W-1:2]);

  // Read FSM next state
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_RESP;
      R_RESP:  if (r_rvalid && s_axi_rready) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Read mux over current register values; out-of-map reads return zero
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_SLVERR;
    if (w_rd_word == REG_CTRL) begin
      w_rd_data = {r_ctrl, 1'b0};
      w_rd_resp = RESP_OKAY;
    end else if (w_rd_word == REG_STATUS) begin
      w_rd_data = {30'd0, r_done_sticky, core_busy_i};
      w_rd_resp = RESP_OKAY;
    end else begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (w_rd_word == REG_CFG0 + k) begin
          w_rd_data = r_cfg[k];
          w_rd_resp = RESP_OKAY;
        end
      end
    end
  end

  // Read FSM state and response capture at the AR handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_arready  <= (w_rd_state_nxt == R_IDLE);
      r_rvalid   <= (w_rd_state_nxt == R_RESP);
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

  // Protection bits, byte offsets and the always-zero CTRL[0] merge result
  // carry no meaning for this block.
  logic w_unused;
  assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                      s_axi_araddr[1:0], w_ctrl_merged[0]};

endmodule
`default_nettype wire

// File: tb/tb_mayo_keygen_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mayo_keygen_axil_slave
//  Brief    : Directed self-checking bench for mayo_keygen_axil_slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mayo_keygen_axil_slave;

  localparam int ADDR_W  = 6;
  localparam int NUM_CFG = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [ADDR_W-1:0]     awaddr = '0;
  logic                  awvalid = 1'b0;
  logic                  awready;
  logic [31:0]           wdata = '0;
  logic [3:0]            wstrb = '0;
  logic                  wvalid = 1'b0;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready = 1'b0;
  logic [ADDR_W-1:0]     araddr = '0;
  logic                  arvalid = 1'b0;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready = 1'b0;
  logic                  core_start;
  logic                  core_busy = 1'b0;
  logic                  core_done = 1'b0;
  logic [NUM_CFG*32-1:0] cfg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mayo_keygen_axil_slave #(.ADDR_W(ADDR_W), .DATA_W(32), .NUM_CFG(NUM_CFG)) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (3'b000),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (3'b000),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .core_start_o  (core_start),
    .core_busy_i   (core_busy),
    .core_done_i   (core_done),
    .cfg_o         (cfg)
  );

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Full write transaction with AW and W presented together
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, ha, hw;
    int t;
    aw_done = 0; w_done = 0; t = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && t < 50) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(posedge clk);
      @(negedge clk);
      if (ha) begin awvalid = 1'b0; aw_done = 1; end
      if (hw) begin wvalid = 1'b0; w_done = 1; end
      t++;
    end
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", 32'd0, 32'd1);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bvalid) check("bvalid_timeout", 32'd0, 32'd1);
    resp = bresp;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Full read transaction; rvalid must follow the AR handshake by one cycle
  task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int t;
    t = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!arready) check("arready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rd_latency", 32'(rvalid), 32'd1);
    t = 0;
    while (!rvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;

    // Reset state
    #23;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_start",   32'(core_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic write / readback
    axi_write(6'h00, 32'h1, 4'hF, r); check("wr00_resp", 32'(r), 32'd0);
    axi_write(6'h08, 32'h2, 4'hF, r); check("wr08_resp", 32'(r), 32'd0);
    axi_write(6'h0C, 32'h3, 4'hF, r); check("wr0C_resp", 32'(r), 32'd0);
    axi_write(6'h10, 32'h4, 4'hF, r); check("wr10_resp", 32'(r), 32'd0);
    axi_read(6'h00, d, r); check("rd00", d, 32'h0); check("rd00_resp", 32'(r), 32'd0);
    axi_read(6'h08, d, r); check("rd08", d, 32'h2); check("rd08_resp", 32'(r), 32'd0);
    axi_read(6'h0C, d, r); check("rd0C", d, 32'h3);
    axi_read(6'h10, d, r); check("rd10", d, 32'h4);
    check("cfg_o_0", cfg[31:0], 32'h2);
    check("cfg_o_2", cfg[95:64], 32'h4);

    // Byte-strobe merge
    axi_write(6'h08, 32'h11223344, 4'hF, r);
    axi_write(6'h08, 32'hAABBCCDD, 4'b0101, r);
    axi_read(6'h08, d, r); check("strb_merge", d, 32'h11BB33DD);

    // W three cycles ahead of AW, B held off for five cycles
    @(negedge clk);
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0;
    check("wready_after_w", 32'(wready), 32'd0);
    repeat (2) @(negedge clk);
    awaddr = 6'h0C; awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("b_hold_valid", 32'(bvalid), 32'd1);
      check("b_hold_resp", 32'(bresp), 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    check("b_dropped", 32'(bvalid), 32'd0);
    axi_read(6'h0C, d, r); check("w_first_data", d, 32'h55);

    // START pulse timing
    @(negedge clk);
    awaddr = 6'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    check("start_before", 32'(core_start), 32'd0);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("start_pulse", 32'(core_start), 32'd1);
    @(negedge clk);
    check("start_after", 32'(core_start), 32'd0);
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;

    // done capture, W1C, busy
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); core_done = 1'b0;
    axi_read(6'h04, d, r); check("status_done", d, 32'h2);
    axi_write(6'h04, 32'h2, 4'hF, r);
    axi_read(6'h04, d, r); check("status_w1c", d, 32'h0);
    core_busy = 1'b1;
    axi_read(6'h04, d, r); check("status_busy", d, 32'h1);
    core_busy = 1'b0;

    // CTRL scratch bits
    axi_write(6'h00, 32'h80000006, 4'hF, r);
    axi_read(6'h00, d, r); check("ctrl_scratch", d, 32'h80000006);

    // Out-of-map access
    axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, r); check("oob_bresp", 32'(r), 32'd2);
    axi_read(6'h3C, d, r); check("oob_rresp", 32'(r), 32'd2); check("oob_rdata", d, 32'h0);
    axi_read(6'h08, d, r); check("oob_cfg0_kept", d, 32'h11BB33DD);
    axi_read(6'h00, d, r); check("oob_ctrl_kept", d, 32'h80000006);

    // Unaligned address maps to its word
    axi_read(6'h0B, d, r); check("unaligned_rd", d, 32'h11BB33DD);

    // Asynchronous reset while waiting in W_RESP
    @(negedge clk);
    awaddr = 6'h10; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_bvalid", 32'(bvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cfg_o", 32'(|cfg), 32'd0);
    axi_read(6'h00, d, r); check("rst_rd00", d, 32'h0);
    axi_read(6'h04, d, r); check("rst_rd04", d, 32'h0);
    axi_read(6'h08, d, r); check("rst_rd08", d, 32'h0);
    axi_read(6'h0C, d, r); check("rst_rd0C", d, 32'h0);
    axi_read(6'h10, d, r); check("rst_rd10", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
